// File: rtl/scenic_stream_pkg.sv
// rtl/scenic_stream_pkg.sv - shared stream helpers, select type and lock-FSM encodings
// Purpose : common definitions for the scenic stream blocks (mux, future crossbar/demux).
// Ports   : none (package).
package scenic_stream_pkg;

  // Widest channel index any stream block instance is expected to need (16 channels).
  localparam int unsigned MAX_SEL_W = 4;

  // Generic channel-index container; each instance slices its own
  // logic [SEL_W-1:0] from its NUM_IN parameter.
  typedef logic [MAX_SEL_W-1:0] sel_t;

  // Lock FSM encodings.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Next channel index after idx, wrapping num-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num);
    if (idx + 32'd1 >= num) begin
      return 32'd0;
    end
    return idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with one-hot grant and index
// Purpose : picks the first requester scanning ptr_i, ptr_i+1, ..., NUM_IN-1, 0, ..., ptr_i-1.
// Ports   : req_i  - request vector
//           ptr_i  - highest-priority channel this cycle
//           gnt_o  - one-hot grant (all zero when no request)
//           idx_o  - index of the granted channel (0 when no request)
//           any_o  - at least one request present
module rr_arbiter #(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              any_o
);

  logic found;

  // Two passes avoid modulo index arithmetic: first the channels at or
  // above the pointer, then the ones below it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && req_i[i] && (SEL_W'(i) >= ptr_i)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && req_i[i] && (SEL_W'(i) < ptr_i)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = SEL_W'(i);
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/stream_rr_mux.sv
// rtl/stream_rr_mux.sv - N-to-1 round-robin stream mux with packet lock and registered output
// Purpose : merges per-lane result streams onto one shared bus toward writeback.
// Ports   : clk, rst_n              - clock, synchronous active-low reset
//           in_valid/in_data/in_last - per-channel input beats
//           in_ready                 - per-channel accept, at most one bit high
//           out_valid/out_data/out_last/out_sel - registered output beat and its source channel
//           out_ready                - downstream accept
//           busy                     - a packet grant is locked
module stream_rr_mux
  import scenic_stream_pkg::*;
#(
  parameter  int NUM_IN      = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int PACKET_MODE = 1,
  localparam int SEL_W       = $clog2(NUM_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IN-1:0]     in_valid,
  input  logic [DATA_WIDTH-1:0] in_data [NUM_IN],
  input  logic [NUM_IN-1:0]     in_last,
  output logic [NUM_IN-1:0]     in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready,
  output logic                  busy
);

  logic [0:0]            state_q, state_d;
  logic [SEL_W-1:0]      owner_q, owner_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [SEL_W-1:0]      out_sel_q, out_sel_d;

  logic [NUM_IN-1:0]     arb_gnt;
  logic [SEL_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  locked;
  logic                  can_load;
  logic [SEL_W-1:0]      cur;
  logic [SEL_W-1:0]      cur_next;
  logic                  cur_last;
  logic                  xfer;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign locked   = (PACKET_MODE != 0) && (state_q == ST_LOCKED);
  assign can_load = !out_valid_q || out_ready;
  assign cur      = locked ? owner_q : arb_idx;
  assign cur_next = SEL_W'(wrap_inc(32'(cur), NUM_IN));
  assign cur_last = in_last[cur];

  // While locked the owner is offered the slot even when it has nothing to
  // send, so other channels see a bubble rather than sneaking into a packet.
  always_comb begin
    in_ready = '0;
    if (rst_n && can_load) begin
      if (locked) begin
        for (int i = 0; i < NUM_IN; i++) begin
          in_ready[i] = (owner_q == SEL_W'(i));
        end
      end else if (arb_any) begin
        in_ready = arb_gnt;
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[cur];
      out_last_d  = cur_last;
      out_sel_d   = cur;
      if (PACKET_MODE != 0) begin
        // Pointer only moves at packet end, so a single-beat packet
        // advances it without ever entering LOCKED.
        if (cur_last) begin
          state_d = ST_IDLE;
          ptr_d   = cur_next;
        end else if (!locked) begin
          state_d = ST_LOCKED;
          owner_d = cur;
        end
      end else begin
        ptr_d = cur_next;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign busy      = locked;

endmodule

// File: doc/stream_rr_mux.md
Name: stream_rr_mux

Overview:
- Parametrised N-to-1 streaming multiplexer with valid/ready handshakes on every port and round-robin arbitration.
- Optionally locks the grant for a whole packet, until the beat carrying last.
- Has a registered output stage that sustains one beat per cycle.
- Merges per-lane result streams (PE rows, accumulator banks) onto a single shared bus toward the writeback/output buffer.

Parameters:
NUM_IN, 4, number of input channels; legal range 2..16.
DATA_WIDTH, 8, width of each data beat in bits.
PACKET_MODE, 1, 1 = grant held from first beat until the beat with last; 0 = re-arbitrate every beat.
SEL_W, $clog2(NUM_IN), width of the channel index; derived, not overridden.

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst_n  input  1  synchronous active-low reset.
in_valid  input  [NUM_IN]  per-channel beat valid.
in_data  input  [NUM_IN][DATA_WIDTH]  per-channel beat data, unpacked array.
in_last  input  [NUM_IN]  per-channel end-of-packet marker.
in_ready  output  [NUM_IN]  per-channel accept; at most one bit high per cycle.
out_valid  output  1  registered output beat valid.
out_data  output  DATA_WIDTH  registered output data.
out_last  output  1  registered end-of-packet marker.
out_sel  output  SEL_W  channel index of the current output beat.
out_ready  input  1  downstream accept.
busy  output  1  high while a packet grant is locked.

Behaviour:
- Reset (rst_n low at a clk edge) clears out_valid, out_data, out_last, out_sel, busy, the rr pointer (ptr = 0) and the lock.
- Reset mid-packet drops the held beat and releases the lock. No beat may appear after reset until a new in_valid arrives.
- can_load = !out_valid || out_ready. The output register accepts a new beat when the slot is empty or drains in the same cycle, so a full stream runs at one beat per cycle.
- Candidate channel cur:
  - If locked, cur = owner.
  - If not locked, cur = the first i with in_valid[i] set, scanning ptr, ptr+1, ... NUM_IN-1, 0, ... ptr-1.
  - Scan is combinational.
- in_ready[cur] = can_load. This holds even when in_valid[cur] is low, and only while locked or while some in_valid is set. All other in_ready bits are 0.
- in_ready never depends combinationally on in_data or in_last.
- Transfer on channel i = in_valid[i] && in_ready[i]. Next edge: out_valid=1, out_data=in_data[i], out_last=in_last[i], out_sel=i.
- If out_ready=1 and there is no transfer, out_valid goes to 0. out_data, out_last and out_sel hold their last values.
- While out_valid=1 && out_ready=0, out_* must hold stable.
- State machine, PACKET_MODE=1:
  - IDLE to LOCKED on a transfer with in_last=0; owner = cur.
  - LOCKED to IDLE on a transfer from owner with in_last=1; ptr = owner+1, wrapping NUM_IN-1 to 0.
  - A single-beat packet (in_last=1 on the first beat) stays in IDLE and advances ptr.
  - In LOCKED, other channels' in_valid are ignored, even when owner is idle (bubble).
- PACKET_MODE=0: never locks; busy is tied 0; ptr = cur+1 after every transfer; in_last is passed through only.
- busy = LOCKED.
- Latency: input transfer to out_valid is exactly 1 cycle.
- No valid inputs and no lock: all in_ready are 0 and nothing changes except output drain.
- Fairness: with all channels continuously valid in PACKET_MODE=0, grants cycle 0,1,...,NUM_IN-1,0.

Decomposition:
- Shared package scenic_stream_pkg: localparam helpers and a sel_t typedef (logic [SEL_W-1:0] is built per instance from the parameter).
- Sub-module rr_arbiter: NUM_IN parameter; inputs req and ptr; outputs a one-hot grant plus an index. Purely combinational, reusable by future crossbar and demux-router blocks.
- The top level owns the lock FSM, the ptr register and the output register slice.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0, busy=0; first grant after release goes to ch0.
- PACKET_MODE=0, NUM_IN=4, all channels valid, out_ready=1, data=ch index -> out_data sequence 0,1,2,3,0,1 at one beat/cycle.
- PACKET_MODE=1: ch2 sends a 3-beat packet (0xA0,0xA1,0xA2 with last on 0xA2) while ch0 is valid throughout.
  -> out_sel=2 for all 3 beats, busy=1 until the last transfer, then ch3 if valid, else ch0, gets the next grant.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> out_data/out_last/out_sel stable, in_ready all 0, no beat lost or duplicated once out_ready=1.
- Reset mid-packet: assert rst_n=0 on beat 2 of 4 from ch1 -> busy=0, out_valid=0; a ch3 single-beat packet 0x55 after reset emerges with out_sel=3.
- Wrap: ptr=3 (last grant ch2), only ch0 and ch3 valid -> ch3 granted first, then ch0.
